l1_mem_arbiter: RTL
===================

Name: l1_mem_arbiter

Overview:
- Shares the single main-memory port between the L1 instruction-cache refill path and the L1 data-cache refill/write-back path.
- Arbitrates between the two requesters and sequences one whole-block burst of BLOCK_WORDS words per grant.
- Returns read data word by word and signals block completion to the owning cache controller.
- Sits between both L1 cache controllers and the backing memory model, below the pipelined CPU's Imem/Dmem ports.

Parameters:
ADDR_W, 32, address width in bits
DATA_W, 32, word width in bits
BLOCK_WORDS, 4, words per cache block; must be a power of two, at least 2
STARVE_LIMIT, 4, consecutive D-cache grants while ic_req is pending before I-cache is forced to win

Ports:
clock  in  1  system clock, rising edge
reset  in  1  synchronous, active-low reset
ic_req  in  1  I-cache block read request; held until ic_done
ic_addr  in  ADDR_W  I-cache miss address; any byte address
ic_gnt  out  1  one-cycle pulse: I-cache transfer started
ic_rvalid  out  1  ic_rdata valid this cycle
ic_rdata  out  DATA_W  refill word, in beat order
ic_done  out  1  one-cycle pulse: I-cache block complete
dc_req  in  1  D-cache block request; held until dc_done
dc_we  in  1  1 = write-back block, 0 = refill read
dc_addr  in  ADDR_W  D-cache block address; any byte address
dc_wdata  in  DATA_W  current write-back word
dc_wnext  out  1  current write word accepted; D-cache advances dc_wdata next cycle
dc_gnt  out  1  one-cycle pulse: D-cache transfer started
dc_rvalid  out  1  dc_rdata valid
dc_rdata  out  DATA_W  refill word
dc_done  out  1  one-cycle pulse: D-cache block complete
mem_en  out  1  memory access request, level
mem_we  out  1  memory write
mem_addr  out  ADDR_W  memory word byte address
mem_wdata  out  DATA_W  memory write data
mem_ready  in  1  beat completes this cycle when mem_en is high
mem_rdata  in  DATA_W  read data, valid with mem_ready
busy  out  1  state is not IDLE
owner  out  1  0 = I-cache, 1 = D-cache; holds last value when idle

Behaviour:
- Reset (clock edge with reset = 0):
  - State goes to IDLE; beat counter, starve counter and owner are cleared.
  - All strobes, mem_en, mem_we and busy are 0. rdata registers are 0.
  - A transfer in progress is abandoned with no done pulse.
- State machine: IDLE -> XFER -> DONE -> IDLE.
- IDLE arbitration, evaluated each cycle:
  - dc_req alone -> D-cache wins. ic_req alone -> I-cache wins.
  - Both pending -> D-cache wins unless starve == STARVE_LIMIT, in which case I-cache wins.
  - The winner's address and dc_we are latched. Base address = addr with its low log2(BLOCK_WORDS)+2 bits cleared. Beat counter = 0. Next state is XFER.
- starve counter (saturating):
  - Increments when D-cache wins while ic_req is high.
  - Clears when I-cache wins or when ic_req is low in IDLE.
- XFER:
  - mem_en = 1. mem_we = latched dc_we when owner is D, else 0.
  - mem_addr = base + 4*beat. Offset wraps within the block; the base is never modified.
  - xx_gnt is 1 only in the first XFER cycle.
  - mem_wdata = dc_wdata (combinational). dc_wnext = mem_en & mem_we & mem_ready (combinational).
  - On mem_ready: read data is registered into the owner's rdata, and owner's rvalid goes to 1 the next cycle for exactly one cycle. The beat counter increments.
  - mem_ready low: outputs hold, no timeout.
  - mem_ready high on beat BLOCK_WORDS-1 -> next state is DONE.
- DONE:
  - The owner's done pulses for one cycle; for reads, the last rvalid coincides with done.
  - mem_en = 0. Next state is IDLE.
  - At least one IDLE cycle separates consecutive bursts.
- Requests:
  - A request deasserted after grant is ignored; the burst runs to completion.
  - A request arriving during XFER or DONE waits for IDLE.
  - The non-owner's gnt, rvalid, done and wnext stay 0 throughout.
- Write bursts produce no rvalid.

Test Plan:
- Read burst timing: ic_req=1, ic_addr=0x0000_003C, mem_ready tied to 1, mem_rdata = address.
  - Required: ic_gnt in cycle 1.
  - mem_addr sequence 0x30, 0x34, 0x38, 0x3C.
  - ic_rvalid in cycles 2-5 with data 0x30..0x3C.
  - ic_done in cycle 5 only; busy 0 in cycle 6.
- Simultaneous requests: ic_req and dc_req (read, dc_addr=0x100) rise together.
  - Required: dc_gnt first; D-cache beats at 0x100..0x10C.
  - ic_gnt follows after dc_done and one IDLE cycle.
- Starvation guard: dc_req held continuously, ic_req held high.
  - Required: exactly 4 D-cache bursts, then an I-cache burst, then D-cache resumes.
- Write-back with wait states: dc_we=1, dc_addr=0x200, mem_ready pattern 0,1,0,0,1,1,0,1.
  - Required: mem_we=1 throughout.
  - dc_wnext asserts only on the four ready cycles.
  - mem_addr advances 0x200..0x20C only after each ready.
  - No dc_rvalid; dc_done pulses once.
- Reset mid-burst: assert reset for one edge during beat 2 of an I-cache read.
  - Required: next cycle mem_en=0, busy=0, no ic_done.
  - A fresh ic_req restarts at beat 0.
- Early deassert: ic_req dropped the cycle after ic_gnt.
  - Required: all 4 beats complete and ic_done still pulses.

Source files
------------

// File: rtl/l1_mem_arbiter.sv
`default_nettype none
// ============================================================================
// l1_mem_arbiter : shares one memory port between I-cache and D-cache bursts
// Revision 1.0 - initial release
// ============================================================================
module l1_mem_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int BLOCK_WORDS  = 4,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              ic_req,
    input  logic [ADDR_W-1:0] ic_addr,
    output logic              ic_gnt,
    output logic              ic_rvalid,
    output logic [DATA_W-1:0] ic_rdata,
    output logic              ic_done,
    input  logic              dc_req,
    input  logic              dc_we,
    input  logic [ADDR_W-1:0] dc_addr,
    input  logic [DATA_W-1:0] dc_wdata,
    output logic              dc_wnext,
    output logic              dc_gnt,
    output logic              dc_rvalid,
    output logic [DATA_W-1:0] dc_rdata,
    output logic              dc_done,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ready,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy,
    output logic              owner
);
    localparam int c_beat_w   = $clog2(BLOCK_WORDS);
    localparam int c_off_w    = c_beat_w + 2;
    localparam int c_starve_w = $clog2(STARVE_LIMIT + 1);
    localparam logic [c_beat_w-1:0]   c_last_beat  = c_beat_w'(BLOCK_WORDS - 1);
    localparam logic [c_starve_w-1:0] c_starve_max = c_starve_w'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_XFER = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t                     r_state;
    state_t                     w_state_nxt;
    logic [c_beat_w-1:0]        r_beat;
    logic [c_starve_w-1:0]      r_starve;
    logic [ADDR_W-c_off_w-1:0]  r_base;
    logic                       r_owner;
    logic                       r_we;
    logic                       r_first;
    logic                       r_ic_rvalid;
    logic                       r_dc_rvalid;
    logic [DATA_W-1:0]          r_ic_rdata;
    logic [DATA_W-1:0]          r_dc_rdata;
    logic                       w_pick_ic;
    logic                       w_pick_dc;
    logic                       w_beat_ok;

    // Block offset bits of the request addresses are dropped by design.
    logic w_unused_offset;
    assign w_unused_offset = ^{ic_addr[c_off_w-1:0], dc_addr[c_off_w-1:0]};

    always_comb begin
        w_state_nxt = r_state;
        w_pick_ic   = 1'b0;
        w_pick_dc   = 1'b0;
        mem_en      = 1'b0;
        mem_we      = 1'b0;
        ic_gnt      = 1'b0;
        dc_gnt      = 1'b0;
        ic_done     = 1'b0;
        dc_done     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                // D-cache wins ties until the I-cache has been passed over STARVE_LIMIT times
                if (dc_req && !(ic_req && r_starve == c_starve_max)) begin
                    w_pick_dc = 1'b1;
                end else if (ic_req) begin
                    w_pick_ic = 1'b1;
                end
                if (w_pick_dc || w_pick_ic) begin
                    w_state_nxt = ST_XFER;
                end
            end
            ST_XFER: begin
                mem_en = 1'b1;
                mem_we = r_owner & r_we;
                ic_gnt = r_first & ~r_owner;
                dc_gnt = r_first & r_owner;
                if (mem_ready && r_beat == c_last_beat) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                ic_done     = ~r_owner;
                dc_done     = r_owner;
                w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    assign w_beat_ok = mem_en & mem_ready;
    assign mem_addr  = {r_base, r_beat, 2'b00};
    assign mem_wdata = dc_wdata;
    assign dc_wnext  = mem_en & mem_we & mem_ready;
    assign busy      = (r_state != ST_IDLE);
    assign owner     = r_owner;
    assign ic_rvalid = r_ic_rvalid;
    assign dc_rvalid = r_dc_rvalid;
    assign ic_rdata  = r_ic_rdata;
    assign dc_rdata  = r_dc_rdata;

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state     <= ST_IDLE;
            r_beat      <= '0;
            r_starve    <= '0;
            r_base      <= '0;
            r_owner     <= 1'b0;
            r_we        <= 1'b0;
            r_first     <= 1'b0;
            r_ic_rvalid <= 1'b0;
            r_dc_rvalid <= 1'b0;
            r_ic_rdata  <= '0;
            r_dc_rdata  <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_first     <= w_pick_ic | w_pick_dc;
            r_ic_rvalid <= w_beat_ok & ~r_owner;
            r_dc_rvalid <= w_beat_ok & r_owner & ~r_we;
            if (w_beat_ok) begin
                r_beat <= r_beat + 1'b1;
                if (!r_owner) begin
                    r_ic_rdata <= mem_rdata;
                end else if (!r_we) begin
                    r_dc_rdata <= mem_rdata;
                end
            end
            if (r_state == ST_IDLE) begin
                if (w_pick_dc) begin
                    r_owner <= 1'b1;
                    r_we    <= dc_we;
                    r_base  <= dc_addr[ADDR_W-1:c_off_w];
                    r_beat  <= '0;
                end else if (w_pick_ic) begin
                    r_owner <= 1'b0;
                    r_we    <= 1'b0;
                    r_base  <= ic_addr[ADDR_W-1:c_off_w];
                    r_beat  <= '0;
                end
                if (w_pick_dc && ic_req) begin
                    if (r_starve != c_starve_max) begin
                        r_starve <= r_starve + 1'b1;
                    end
                end else begin
                    r_starve <= '0;
                end
            end
        end
    end

endmodule
`default_nettype wire
